// File: rtl/rc5_tx.sv
// RC5 infrared transmitter on a CSR page: sends a start bit plus a 13-bit word,
// Manchester coded on the 570 Hz x16 timing base, with a 25%-duty carrier output.
module rc5_tx #(
    parameter logic [3:0] csr_addr     = 4'h0,
    parameter int         clk_freq     = 100000000,
    parameter int         carrier_freq = 36000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [14:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        tx_irq,
    output logic        tx,
    output logic        tx_ir
);

    localparam int DIVISOR = clk_freq / 570 / 16;
    localparam int DIV_W   = $clog2(DIVISOR);
    localparam int CP      = clk_freq / carrier_freq;
    localparam int CAR_W   = $clog2(CP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CP - 1);
    localparam logic [CAR_W-1:0] CAR_HIGH = CAR_W'(CP / 4);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_reg, state_next;
    logic [13:0]      frame_reg, frame_next;
    logic [12:0]      data_reg, data_next;
    logic [4:0]       half_reg, half_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [2:0]       tick_reg, tick_next;
    logic [CAR_W-1:0] car_reg, car_next;
    logic             cen_reg, cen_next;
    logic             tx_reg, tx_next;
    logic             tx_ir_reg, tx_ir_next;
    logic             irq_reg, irq_next;
    logic [31:0]      csr_do_reg, csr_do_next;

    logic csr_sel, wr_en, start, tick, half_done, frame_done, busy;
    logic [3:0] bit_idx;
    logic cur_bit;
    logic unused_bits;

    assign csr_sel    = (csr_a[14:10] == {1'b0, csr_addr});
    assign wr_en      = csr_sel & csr_we;
    assign busy       = (state_reg == SEND);
    assign start      = wr_en & ~csr_a[0] & ~busy;
    assign tick       = (div_reg == DIV_LAST);
    assign half_done  = tick & (tick_reg == 3'd7);
    assign frame_done = busy & half_done & (half_reg == 5'd27);
    assign unused_bits = &{1'b0, csr_di[31:13], csr_a[9:1]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg  <= IDLE;
            frame_reg  <= '0;
            data_reg   <= '0;
            half_reg   <= '0;
            div_reg    <= '0;
            tick_reg   <= '0;
            car_reg    <= '0;
            cen_reg    <= 1'b1;
            tx_reg     <= 1'b0;
            tx_ir_reg  <= 1'b0;
            irq_reg    <= 1'b0;
            csr_do_reg <= '0;
        end else begin
            state_reg  <= state_next;
            frame_reg  <= frame_next;
            data_reg   <= data_next;
            half_reg   <= half_next;
            div_reg    <= div_next;
            tick_reg   <= tick_next;
            car_reg    <= car_next;
            cen_reg    <= cen_next;
            tx_reg     <= tx_next;
            tx_ir_reg  <= tx_ir_next;
            irq_reg    <= irq_next;
            csr_do_reg <= csr_do_next;
        end
    end

    // Next state plus datapath; counters restart on an accepted write so every frame is timed identically.
    always_comb begin
        state_next = state_reg;
        frame_next = frame_reg;
        data_next  = data_reg;
        half_next  = half_reg;
        div_next   = tick ? '0 : div_reg + 1'b1;
        tick_next  = tick ? tick_reg + 3'd1 : tick_reg;
        car_next   = (car_reg == CAR_LAST) ? '0 : car_reg + 1'b1;
        cen_next   = (wr_en & csr_a[0]) ? csr_di[0] : cen_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SEND;
                    frame_next = {1'b1, csr_di[12:0]};
                    data_next  = csr_di[12:0];
                    half_next  = '0;
                    div_next   = '0;
                    tick_next  = '0;
                    car_next   = '0;
                end
            end
            SEND: begin
                if (half_done)
                    half_next = half_reg + 5'd1;
                if (frame_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // First half of a bit carries its complement, second half the bit itself.
    always_comb begin
        bit_idx     = 4'd13 - half_next[4:1];
        cur_bit     = frame_next[bit_idx];
        tx_next     = (state_next == SEND) & (half_next[0] ? cur_bit : ~cur_bit);
        tx_ir_next  = tx_next & ((car_next < CAR_HIGH) | ~cen_next);
        irq_next    = frame_done;
        csr_do_next = '0;
        if (csr_sel)
            csr_do_next = csr_a[0] ? {31'd0, cen_reg} : {18'd0, busy, data_reg};
    end

    assign csr_do = csr_do_reg;
    assign tx_irq = irq_reg;
    assign tx     = tx_reg;
    assign tx_ir  = tx_ir_reg;

endmodule

// File: tb/tb_rc5_tx.sv
// Directed bench for rc5_tx at clk_freq=912000 (800-cycle half bits) and a 25-cycle carrier.
module tb_rc5_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [14:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        tx_irq, tx, tx_ir;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    rc5_tx #(.csr_addr(4'h0), .clk_freq(912000), .carrier_freq(36000)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(csr_do), .tx_irq(tx_irq), .tx(tx), .tx_ir(tx_ir)
    );

    // Leaves the bench at the falling edge right after the accepting rising edge (frame cycle 0).
    task automatic csr_write(input logic [14:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0; csr_a = '0; csr_di = '0;
    endtask

    // Acts as the loopback receiver: samples mid-half, checks tx_ir every cycle, stops at tx_irq.
    task automatic run_frame(input int inj_k, input logic [14:0] inj_a, input logic [31:0] inj_d,
                             output logic [13:0] word, output int irq_k, output int bad_man,
                             output int bad_ir, output logic busy_mid);
        logic [27:0] halves;
        bit cen;
        cen = 1'b1; halves = '0; irq_k = -1; bad_ir = 0; busy_mid = 1'b0; bad_man = 0;
        for (int k = 0; k <= 23000; k++) begin
            if (k == inj_k + 1 && inj_a[0]) cen = inj_d[0];
            if (tx_ir !== (tx & (((k % 25) < 6) | !cen))) bad_ir++;
            if (tx_irq === 1'b1) begin
                irq_k = k;
                break;
            end
            if ((k % 800) == 400 && k < 22400) halves[k / 800] = tx;
            if (k == 1100) busy_mid = csr_do[13];
            if (k == inj_k) begin
                csr_a = inj_a; csr_di = inj_d; csr_we = 1'b1;
            end else if (k == inj_k + 1) begin
                csr_we = 1'b0; csr_a = '0; csr_di = '0;
            end
            @(negedge sys_clk);
        end
        for (int h = 0; h < 14; h++) begin
            word[13 - h] = halves[2 * h + 1];
            if (halves[2 * h] === halves[2 * h + 1]) bad_man++;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; csr_we = 1'b0; csr_a = '0; csr_di = '0;
        repeat (3) @(negedge sys_clk);
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL reset_tx: got %b, expected 0", tx); end
        tests++; if (tx_ir !== 1'b0) begin fails++; $display("FAIL reset_tx_ir: got %b, expected 0", tx_ir); end
        tests++; if (tx_irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b, expected 0", tx_irq); end
        tests++; if (csr_do !== 32'd0) begin fails++; $display("FAIL reset_csr_do: got %h, expected 0", csr_do); end
        sys_rst = 1'b0; csr_a = 15'h0001;
        @(negedge sys_clk);
        tests++; if (csr_do !== 32'd1) begin fails++; $display("FAIL reset_carrier_en: got %h, expected 1", csr_do); end
        csr_a = '0;
        @(negedge sys_clk);
        tests++; if (csr_do !== 32'd0) begin fails++; $display("FAIL reset_reg0: got %h, expected 0", csr_do); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_frame_busy();
        logic [13:0] w; int ik, bm, bi; logic bmid;
        csr_write(15'h0000, 32'h1ABC);
        run_frame(1000, 15'h0000, 32'h0, w, ik, bm, bi, bmid);
        tests++; if (w !== 14'h3ABC) begin fails++; $display("FAIL frame_word: got %h, expected 3abc", w); end
        tests++; if (ik !== 22400) begin fails++; $display("FAIL frame_irq_time: got %0d, expected 22400", ik); end
        tests++; if (bm !== 0) begin fails++; $display("FAIL frame_manchester: got %0d bad bits, expected 0", bm); end
        tests++; if (bi !== 0) begin fails++; $display("FAIL frame_carrier: got %0d bad cycles, expected 0", bi); end
        tests++; if (bmid !== 1'b1) begin fails++; $display("FAIL busy_during: got %b, expected 1", bmid); end
        @(negedge sys_clk);
        tests++; if (tx_irq !== 1'b0) begin fails++; $display("FAIL irq_pulse: got %b, expected 0", tx_irq); end
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL frame_tx_after: got %b, expected 0", tx); end
        tests++; if (csr_do !== 32'h0000_1ABC) begin fails++; $display("FAIL busy_after_reg0: got %h, expected 00001abc", csr_do); end
        $display("[TB] test_frame_busy word=%h irq_at=%0d", w, ik);
    endtask

    task automatic test_abort();
        logic tx_after, irq_seen, bmid, tx_at;
        logic [31:0] do_at;
        tx_after = 1'b0; irq_seen = 1'b0; bmid = 1'b0; tx_at = 1'b1; do_at = '1;
        csr_write(15'h0000, 32'h0555);
        for (int k = 0; k <= 6000; k++) begin
            if (k == 1100) bmid = csr_do[13];
            if (k == 5001) tx_at = tx;
            if (k >= 5001 && tx === 1'b1) tx_after = 1'b1;
            if (tx_irq === 1'b1) irq_seen = 1'b1;
            if (k == 6000) do_at = csr_do;
            if (k == 5000) sys_rst = 1'b1;
            if (k == 5001) sys_rst = 1'b0;
            @(negedge sys_clk);
        end
        tests++; if (bmid !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b, expected 1", bmid); end
        tests++; if (tx_at !== 1'b0) begin fails++; $display("FAIL abort_tx: got %b, expected 0", tx_at); end
        tests++; if (tx_after !== 1'b0) begin fails++; $display("FAIL abort_tx_quiet: got %b, expected 0", tx_after); end
        tests++; if (irq_seen !== 1'b0) begin fails++; $display("FAIL abort_irq: got %b, expected 0", irq_seen); end
        tests++; if (do_at !== 32'd0) begin fails++; $display("FAIL abort_reg0: got %h, expected 0", do_at); end
        $display("[TB] test_abort done");
    endtask

    task automatic test_csr_decode();
        logic tx_seen;
        tx_seen = 1'b0;
        @(negedge sys_clk);
        csr_a = 15'h0400; csr_di = 32'h1ABC; csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
        tests++; if (csr_do !== 32'd0) begin fails++; $display("FAIL decode_read0: got %h, expected 0", csr_do); end
        csr_a = 15'h0401;
        @(negedge sys_clk);
        tests++; if (csr_do !== 32'd0) begin fails++; $display("FAIL decode_read1: got %h, expected 0", csr_do); end
        csr_a = '0; csr_di = '0;
        for (int k = 0; k < 900; k++) begin
            if (tx === 1'b1 || tx_irq === 1'b1) tx_seen = 1'b1;
            @(negedge sys_clk);
        end
        tests++; if (tx_seen !== 1'b0) begin fails++; $display("FAIL decode_no_frame: got %b, expected 0", tx_seen); end
        tests++; if (csr_do !== 32'd0) begin fails++; $display("FAIL decode_reg0: got %h, expected 0", csr_do); end
        csr_a = 15'h0001;
        @(negedge sys_clk);
        tests++; if (csr_do !== 32'd1) begin fails++; $display("FAIL decode_sel_reg1: got %h, expected 1", csr_do); end
        csr_a = '0;
        $display("[TB] test_csr_decode done");
    endtask

    task automatic test_back_to_back();
        logic [13:0] w1, w2; int ik1, ik2, bm1, bm2, bi1, bi2; logic bmid;
        csr_write(15'h0000, 32'h1ABC);
        run_frame(-5, 15'h0000, 32'h0, w1, ik1, bm1, bi1, bmid);
        csr_a = '0; csr_di = 32'h0001; csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0; csr_di = '0;
        // Second frame also turns the carrier off mid-frame.
        run_frame(3000, 15'h0001, 32'h0, w2, ik2, bm2, bi2, bmid);
        tests++; if (w1 !== 14'h3ABC) begin fails++; $display("FAIL b2b_word1: got %h, expected 3abc", w1); end
        tests++; if (ik1 !== 22400) begin fails++; $display("FAIL b2b_irq1: got %0d, expected 22400", ik1); end
        tests++; if (bm1 !== 0) begin fails++; $display("FAIL b2b_manchester1: got %0d, expected 0", bm1); end
        tests++; if (bi1 !== 0) begin fails++; $display("FAIL b2b_carrier1: got %0d, expected 0", bi1); end
        tests++; if (w2 !== 14'h2001) begin fails++; $display("FAIL b2b_word2: got %h, expected 2001", w2); end
        tests++; if (ik2 !== 22400) begin fails++; $display("FAIL b2b_irq2: got %0d, expected 22400", ik2); end
        tests++; if (bm2 !== 0) begin fails++; $display("FAIL b2b_manchester2: got %0d, expected 0", bm2); end
        tests++; if (bi2 !== 0) begin fails++; $display("FAIL carrier_off_ir: got %0d bad cycles, expected 0", bi2); end
        csr_a = 15'h0001;
        @(negedge sys_clk);
        tests++; if (csr_do !== 32'd0) begin fails++; $display("FAIL carrier_reg1: got %h, expected 0", csr_do); end
        csr_write(15'h0001, 32'h1);
        $display("[TB] test_back_to_back words=%h,%h", w1, w2);
    endtask

    initial begin
        sys_rst = 1'b1; csr_we = 1'b0; csr_a = '0; csr_di = '0;
        test_reset();
        test_frame_busy();
        test_abort();
        test_csr_decode();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
